// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types for the mode arbiter
package arb_pkg;

   typedef enum logic {
      PRIORITY    = 1'b0,
      ROUND_ROBIN = 1'b1
   } arb_mode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int HOLD_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first set request searching upward from start, wrapping
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] idx
);

   int pos;

   // The first hit wins and later hits are ignored, so a zero start gives fixed priority.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int off = 0; off < N; off++) begin
         pos = int'(start) + off;
         if (pos >= N) pos = pos - N;
         if (!found && req[pos]) begin
            found = 1'b1;
            idx   = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/mode_arbiter.sv
// rtl/mode_arbiter.sv - priority / round-robin arbiter with bounded hold and grant checking
module mode_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mode_i,
   input  logic [N_REQ-1:0]         req_i,
   input  logic                     err_clr_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic                     gnt_valid_o,
   output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
   output logic                     err_o
);

   localparam int IW = $clog2(N_REQ);

   arb_state_e          state_q, state_d;
   arb_mode_e           mode_sel;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [IW-1:0]       rr_ptr, rr_ptr_d;
   logic [IW-1:0]       pick_start, pick_idx;
   logic                pick_found;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                err_q, err_set;

   function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
      return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
   endfunction

   assign mode_sel   = arb_mode_e'(mode_i);
   assign pick_start = (mode_sel == ROUND_ROBIN) ? rr_ptr : '0;

   rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req   (req_i),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      idx_d    = idx_q;
      hold_d   = hold_q;
      rr_ptr_d = rr_ptr;
      unique case (state_q)
         IDLE: begin
            gnt_d  = '0;
            idx_d  = '0;
            hold_d = '0;
            if (pick_found) begin
               state_d         = GRANT;
               gnt_d[pick_idx] = 1'b1;
               idx_d           = pick_idx;
               hold_d          = HOLD_W'(1);
               if (mode_sel == ROUND_ROBIN) rr_ptr_d = ptr_inc(pick_idx);
            end
         end
         GRANT: begin
            // Releasing always passes through IDLE, which guarantees the idle gap.
            if (!req_i[idx_q] || hold_q == HOLD_W'(MAX_HOLD)) begin
               state_d = IDLE;
               gnt_d   = '0;
               idx_d   = '0;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            hold_d  = '0;
         end
      endcase
   end

   // Independent watchdog on whatever is about to be registered as the grant.
   assign err_set = ((gnt_d & (gnt_d - 1'b1)) != '0) || ((gnt_d & ~req_i) != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         hold_q  <= '0;
         rr_ptr  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         rr_ptr  <= rr_ptr_d;
         err_q   <= err_set | (err_q & ~err_clr_i);
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_valid_o = |gnt_q;
   assign gnt_idx_o   = idx_q;
   assign err_o       = err_q;

endmodule
